// File: rtl/uio_byte_tx.sv
// uio byte port transmitter: small FIFO from the core, bytes driven onto the
// uio pads with a 4-phase req/ack handshake. The ack is resynchronised, and a
// timeout guards the REQ and RELEASE phases.
module uio_byte_tx #(
  parameter int DEPTH     = 4,    // FIFO entries, power of two, >= 2
  parameter int SETUP_CYC = 1,    // cycles data/oe lead req, >= 1
  parameter int TIMEOUT   = 255   // max wait in REQ/RELEASE, 0 = disabled
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       tx_req,
  input  logic       tx_ack,
  output logic       err,
  input  logic       err_clr,
  output logic [7:0] sent_cnt,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETUP_CYC < 2) ? 1 : $clog2(SETUP_CYC);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_REQ     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ack_m, ack_s;
  logic [1:0]    state;
  logic [SW-1:0] setup_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          fifo_ne, push, pop;
  logic          req_done, rel_done, tmo_fire;

  assign fifo_ne  = (count != '0);
  assign in_ready = (count < (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign busy     = (state != S_IDLE) || fifo_ne;

  // Handshake progress, timeout and pop decisions; a completing handshake
  // beats a timeout landing on the same cycle.
  always_comb begin
    req_done = (state == S_REQ) && ack_s;
    rel_done = (state == S_RELEASE) && !ack_s;
    tmo_fire = 1'b0;
    if (TIMEOUT != 0 && (state == S_REQ || state == S_RELEASE))
      tmo_fire = (tmo_cnt == TW'(TIMEOUT)) && !req_done && !rel_done;
    pop = fifo_ne && ((state == S_IDLE) || rel_done);
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Two-flop resynchroniser for the asynchronous ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= tx_ack;
      ack_s <= ack_m;
    end
  end

  // Handshake FSM with registered pad outputs, error flag and transfer count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      uio_out   <= '0;
      uio_oe    <= '0;
      tx_req    <= 1'b0;
      setup_cnt <= '0;
      tmo_cnt   <= '0;
      err       <= 1'b0;
      sent_cnt  <= '0;
    end else begin
      if (err_clr) err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            uio_out   <= mem[rd_ptr];
            uio_oe    <= 8'hFF;
            setup_cnt <= SW'(SETUP_CYC - 1);
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (setup_cnt == '0) begin
            tx_req  <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_REQ;
          end else begin
            setup_cnt <= setup_cnt - SW'(1);
          end
        end
        S_REQ: begin
          if (req_done) begin
            tx_req  <= 1'b0;
            tmo_cnt <= '0;
            state   <= S_RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_RELEASE: begin
          if (rel_done) begin
            sent_cnt <= sent_cnt + 8'd1;
            if (pop) begin
              // next byte goes straight out, oe stays asserted
              uio_out   <= mem[rd_ptr];
              setup_cnt <= SW'(SETUP_CYC - 1);
              state     <= S_SETUP;
            end else begin
              uio_out <= '0;
              uio_oe  <= '0;
              state   <= S_IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      // Timed-out byte is dropped and the bus released; overrides err_clr.
      if (tmo_fire) begin
        err     <= 1'b1;
        tx_req  <= 1'b0;
        uio_oe  <= '0;
        uio_out <= '0;
        state   <= S_IDLE;
      end
    end
  end

endmodule
